// File: rtl/axi_4lite_pkg.sv
// Shared AXI4-Lite definitions: response codes and the master FSM state encoding.
package axi_4lite_pkg;

  // Response codes, shared by master and slave; passed through unmodified.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Master transaction sequencer states.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdResp = 3'd4,
    StRsp    = 3'd5
  } mst_state_e;

endpackage

// File: rtl/axi_4lite_master.sv
// AXI4-Lite initiator: turns single-beat commands into one AXI4-Lite transaction
// at a time and returns the read data / response code on a valid/ready port.
// Every output is driven straight from a flop, so no valid depends on any ready.
module axi_4lite_master
  import axi_4lite_pkg::*;
#(
  parameter int unsigned AXI_Dwidth    = 32,
  parameter int unsigned AXI_Addrwidth = 4
) (
  input  logic                       AXI_aclk,
  input  logic                       AXI_aresetn,
  // Command port
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AXI_Addrwidth-1:0]   cmd_addr,
  input  logic [AXI_Dwidth-1:0]      cmd_wdata,
  input  logic [AXI_Dwidth/8-1:0]    cmd_wstrb,
  // Response port
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic                       rsp_write,
  output logic [AXI_Dwidth-1:0]      rsp_rdata,
  output logic [1:0]                 rsp_resp,
  // Write address channel
  output logic [AXI_Addrwidth-1:0]   AXI_awaddr,
  output logic                       AXI_awvalid,
  input  logic                       AXI_awready,
  // Write data channel
  output logic [AXI_Dwidth-1:0]      AXI_wdata,
  output logic [AXI_Dwidth/8-1:0]    AXI_wstrb,
  output logic                       AXI_wvalid,
  input  logic                       AXI_wready,
  // Write response channel
  input  logic [1:0]                 AXI_bresp,
  input  logic                       AXI_bvalid,
  output logic                       AXI_bready,
  // Read address channel
  output logic [AXI_Addrwidth-1:0]   AXI_areadaddr,
  output logic [2:0]                 AXI_arprotect,
  output logic                       AXI_arvalid,
  input  logic                       AXI_arready,
  // Read data channel
  input  logic [AXI_Dwidth-1:0]      AXI_rdata,
  input  logic [1:0]                 AXI_rresp,
  input  logic                       AXI_rvalid,
  output logic                       AXI_rready
);

  localparam int unsigned StrbW = AXI_Dwidth / 8;

  mst_state_e state_q, state_d;

  // Per-channel completion flags for the write request phase.
  logic aw_done_q, aw_done_d;
  logic w_done_q, w_done_d;

  logic cmd_ready_q, cmd_ready_d;

  logic                     awvalid_q, awvalid_d;
  logic                     wvalid_q, wvalid_d;
  logic                     arvalid_q, arvalid_d;
  logic                     bready_q, bready_d;
  logic                     rready_q, rready_d;
  logic [AXI_Addrwidth-1:0] awaddr_q, awaddr_d;
  logic [AXI_Addrwidth-1:0] araddr_q, araddr_d;
  logic [AXI_Dwidth-1:0]    wdata_q, wdata_d;
  logic [StrbW-1:0]         wstrb_q, wstrb_d;

  logic                     rsp_valid_q, rsp_valid_d;
  logic                     rsp_write_q, rsp_write_d;
  logic [AXI_Dwidth-1:0]    rsp_rdata_q, rsp_rdata_d;
  logic [1:0]               rsp_resp_q, rsp_resp_d;

  logic aw_hs, w_hs;

  assign aw_hs = awvalid_q & AXI_awready;
  assign w_hs  = wvalid_q & AXI_wready;

  // Next-state and next-output logic for the transaction sequencer.
  always_comb begin
    state_d     = state_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    bready_d    = bready_q;
    rready_d    = rready_q;
    awaddr_d    = awaddr_q;
    araddr_d    = araddr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rsp_valid_d = rsp_valid_q;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          cmd_ready_d = 1'b0;
          if (cmd_write) begin
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWrReq;
          end else begin
            araddr_d  = cmd_addr;
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end

      StWrReq: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (w_hs) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        // Leave as soon as the later of the two handshakes lands.
        if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          bready_d  = 1'b1;
          state_d   = StWrResp;
        end
      end

      StWrResp: begin
        if (AXI_bvalid) begin
          bready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_resp_d  = AXI_bresp;
          state_d     = StRsp;
        end
      end

      StRdReq: begin
        if (AXI_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdResp;
        end
      end

      StRdResp: begin
        if (AXI_rvalid) begin
          rready_d    = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_write_d = 1'b0;
          rsp_rdata_d = AXI_rdata;
          rsp_resp_d  = AXI_rresp;
          state_d     = StRsp;
        end
      end

      StRsp: begin
        // rsp_* payload is left untouched so it stays stable until consumed.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = StIdle;
        end
      end

      default: begin
        awvalid_d   = 1'b0;
        wvalid_d    = 1'b0;
        arvalid_d   = 1'b0;
        bready_d    = 1'b0;
        rready_d    = 1'b0;
        rsp_valid_d = 1'b0;
        aw_done_d   = 1'b0;
        w_done_d    = 1'b0;
        cmd_ready_d = 1'b1;
        state_d     = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge AXI_aclk or negedge AXI_aresetn) begin
    if (!AXI_aresetn) begin
      state_q     <= StIdle;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      bready_q    <= 1'b0;
      rready_q    <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      bready_q    <= bready_d;
      rready_q    <= rready_d;
      awaddr_q    <= awaddr_d;
      araddr_q    <= araddr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_write     = rsp_write_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign AXI_awaddr    = awaddr_q;
  assign AXI_awvalid   = awvalid_q;
  assign AXI_wdata     = wdata_q;
  assign AXI_wstrb     = wstrb_q;
  assign AXI_wvalid    = wvalid_q;
  assign AXI_bready    = bready_q;
  assign AXI_areadaddr = araddr_q;
  assign AXI_arprotect = 3'b000;
  assign AXI_arvalid   = arvalid_q;
  assign AXI_rready    = rready_q;

endmodule

// File: tb/tb_axi_4lite_master.sv
// Bench for axi_4lite_master: behavioural AXI4-Lite slave plus a response scoreboard.
module tb_axi_4lite_master;
  import axi_4lite_pkg::*;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [3:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [3:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic [2:0]  arprot;

  always #5 clk = ~clk;

  axi_4lite_master #(.AXI_Dwidth(32), .AXI_Addrwidth(4)) dut (
    .AXI_aclk(clk), .AXI_aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AXI_awaddr(awaddr), .AXI_awvalid(awvalid), .AXI_awready(awready),
    .AXI_wdata(wdata), .AXI_wstrb(wstrb), .AXI_wvalid(wvalid), .AXI_wready(wready),
    .AXI_bresp(bresp), .AXI_bvalid(bvalid), .AXI_bready(bready),
    .AXI_areadaddr(araddr), .AXI_arprotect(arprot), .AXI_arvalid(arvalid),
    .AXI_arready(arready),
    .AXI_rdata(rdata), .AXI_rresp(rresp), .AXI_rvalid(rvalid), .AXI_rready(rready)
  );

  // Behavioural slave state and configuration
  logic [31:0] mem [4];
  logic [31:0] ref_mem [4];
  int          aw_delay = 0, w_delay = 0, aw_cnt = 0, w_cnt = 0;
  logic [1:0]  bresp_cfg = RESP_OKAY, rresp_cfg = RESP_OKAY;
  bit          b_hold = 0, aw_got = 0, w_got = 0, ar_got = 0;
  logic [3:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int          aw_hs_cnt = 0, w_hs_cnt = 0, b_hs_cnt = 0, ar_hs_cnt = 0;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_fail = 0;

  // Slave: observe handshakes at the edge, drive its outputs 1 time unit later.
  always @(posedge clk) begin : slave
    bit b_hs, r_hs;
    b_hs = bvalid && bready;
    r_hs = rvalid && rready;
    if (!aresetn) begin
      aw_got = 0; w_got = 0; ar_got = 0;
    end else begin
      if (awvalid && awready) begin aw_got = 1; s_awaddr = awaddr; aw_hs_cnt++; end
      if (wvalid && wready) begin w_got = 1; s_wdata = wdata; s_wstrb = wstrb; w_hs_cnt++; end
      if (b_hs) b_hs_cnt++;
      if (arvalid && arready) begin ar_got = 1; s_araddr = araddr; ar_hs_cnt++; end
    end
    #1;
    if (!aresetn) begin
      awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
      aw_cnt = 0; w_cnt = 0;
    end else begin
      if (b_hs) bvalid = 0;
      if (r_hs) rvalid = 0;
      awready = 0;
      if (awvalid) begin
        if (aw_cnt >= aw_delay) awready = 1;
        aw_cnt++;
      end else aw_cnt = 0;
      wready = 0;
      if (wvalid) begin
        if (w_cnt >= w_delay) wready = 1;
        w_cnt++;
      end else w_cnt = 0;
      if (aw_got && w_got && !bvalid && !b_hold) begin
        if (bresp_cfg == RESP_OKAY)
          for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[s_awaddr[3:2]][8*b +: 8] = s_wdata[8*b +: 8];
        bvalid = 1; bresp = bresp_cfg;
        aw_got = 0; w_got = 0;
      end
      arready = arvalid;
      if (ar_got && !rvalid) begin
        rvalid = 1; rdata = mem[s_araddr[3:2]]; rresp = rresp_cfg;
        ar_got = 0;
      end
    end
  end

  // Issue one command, push its expected response, then pop and compare it.
  task automatic do_cmd(input logic wr, input logic [3:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input int stall, output int lat,
                        output int acc_wait);
    exp_t e;
    logic [34:0] snap;
    e.wr    = wr;
    e.resp  = wr ? bresp_cfg : rresp_cfg;
    e.rdata = wr ? 32'h0 : ref_mem[addr[3:2]];
    if (wr && bresp_cfg == RESP_OKAY)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[3:2]][8*b +: 8] = data[8*b +: 8];
    sb.push_back(e);
    lat = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    acc_wait = 0;
    while (!cmd_ready && acc_wait < 50) begin @(negedge clk); acc_wait++; end
    n_cmp++;
    if (!cmd_ready) begin
      n_fail++; $display("FAIL cmd_accept_timeout: cmd_ready=%b want 1", cmd_ready);
      cmd_valid = 0; void'(sb.pop_back()); return;
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin @(negedge clk); lat++; end
    n_cmp++;
    if (!rsp_valid) begin
      n_fail++; $display("FAIL rsp_timeout: rsp_valid=%b want 1", rsp_valid);
      void'(sb.pop_front()); return;
    end
    snap = {rsp_write, rsp_rdata, rsp_resp};
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      if (i == 1) begin
        cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hF; cmd_wdata = 32'hFFFF_FFFF; cmd_wstrb = 4'hF;
      end
      if (i == 2) cmd_valid = 0;
      n_cmp++;
      if (rsp_valid !== 1'b1) begin
        n_fail++; $display("FAIL stall_rsp_valid: got %b want 1", rsp_valid);
      end
      n_cmp++;
      if ({rsp_write, rsp_rdata, rsp_resp} !== snap) begin
        n_fail++; $display("FAIL stall_rsp_stable: got %h want %h",
                           {rsp_write, rsp_rdata, rsp_resp}, snap);
      end
      n_cmp++;
      if (cmd_ready !== 1'b0) begin
        n_fail++; $display("FAIL stall_cmd_ready: got %b want 0", cmd_ready);
      end
    end
    cmd_valid = 0;
    rsp_ready = 1;
    e = sb.pop_front();
    n_cmp++;
    if (rsp_write !== e.wr) begin
      n_fail++; $display("FAIL rsp_write: got %b want %b", rsp_write, e.wr);
    end
    n_cmp++;
    if (rsp_rdata !== e.rdata) begin
      n_fail++; $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e.rdata);
    end
    n_cmp++;
    if (rsp_resp !== e.resp) begin
      n_fail++; $display("FAIL rsp_resp: got %b want %b", rsp_resp, e.resp);
    end
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write} !== 7'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0",
                         {awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_write});
    end
    n_cmp++;
    if ({awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp} !== 78'b0) begin
      n_fail++; $display("FAIL reset_data: got %h want 0",
                         {awaddr, araddr, wdata, wstrb, rsp_rdata, rsp_resp});
    end
    n_cmp++;
    if (arprot !== 3'b000) begin
      n_fail++; $display("FAIL arprotect: got %b want 000", arprot);
    end
    aresetn = 1;
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_basic();
    int lat, acc;
    do_cmd(1, 4'h0, 32'hDEAD_BEEF, 4'hF, 0, lat, acc);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d want 3", lat); end
    do_cmd(0, 4'h0, 32'h0, 4'h0, 0, lat, acc);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL read_latency: got %0d want 3", lat); end
  endtask

  task automatic test_wr_order(input int awd, input int wd);
    int lat, acc, a0, w0, b0;
    a0 = aw_hs_cnt; w0 = w_hs_cnt; b0 = b_hs_cnt;
    aw_delay = awd; w_delay = wd;
    fork
      do_cmd(1, 4'h4, 32'hCAFE_0000 | 32'(awd), 4'hF, 0, lat, acc);
      begin
        logic pav, par, pwv, pwr;
        logic [3:0] pa;
        logic [35:0] pw;
        pav = 0; par = 0; pwv = 0; pwr = 0; pa = 0; pw = 0;
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (pav) begin
            n_cmp++;
            if (awvalid !== !par) begin
              n_fail++; $display("FAIL awvalid_drop: got %b want %b", awvalid, !par);
            end
            if (!par) begin
              n_cmp++;
              if (awaddr !== pa) begin
                n_fail++; $display("FAIL awaddr_stable: got %h want %h", awaddr, pa);
              end
            end
          end
          if (pwv) begin
            n_cmp++;
            if (wvalid !== !pwr) begin
              n_fail++; $display("FAIL wvalid_drop: got %b want %b", wvalid, !pwr);
            end
            if (!pwr) begin
              n_cmp++;
              if ({wdata, wstrb} !== pw) begin
                n_fail++; $display("FAIL w_stable: got %h want %h", {wdata, wstrb}, pw);
              end
            end
          end
          pav = awvalid; par = awready; pa = awaddr;
          pwv = wvalid; pwr = wready; pw = {wdata, wstrb};
        end
      end
    join
    aw_delay = 0; w_delay = 0;
    n_cmp++;
    if (lat !== 6) begin n_fail++; $display("FAIL order_latency: got %0d want 6", lat); end
    n_cmp++;
    if ({aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL order_hs_counts: got aw=%0d w=%0d b=%0d want 1 1 1",
                         aw_hs_cnt - a0, w_hs_cnt - w0, b_hs_cnt - b0);
    end
  endtask

  task automatic test_error_resp();
    int lat, acc, a0, r0;
    a0 = aw_hs_cnt; r0 = ar_hs_cnt;
    bresp_cfg = RESP_SLVERR;
    do_cmd(1, 4'hC, 32'h1111_2222, 4'hF, 0, lat, acc);
    bresp_cfg = RESP_OKAY;
    rresp_cfg = RESP_DECERR;
    do_cmd(0, 4'hC, 32'h0, 4'h0, 0, lat, acc);
    rresp_cfg = RESP_OKAY;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (aw_hs_cnt - a0 !== 1) begin
      n_fail++; $display("FAIL err_no_retry_aw: got %0d want 1", aw_hs_cnt - a0);
    end
    n_cmp++;
    if (ar_hs_cnt - r0 !== 1) begin
      n_fail++; $display("FAIL err_no_retry_ar: got %0d want 1", ar_hs_cnt - r0);
    end
  endtask

  task automatic test_rsp_stall();
    int lat, acc, a0;
    a0 = aw_hs_cnt;
    do_cmd(0, 4'h0, 32'h0, 4'h0, 5, lat, acc);
    @(negedge clk);
    n_cmp++;
    if (aw_hs_cnt !== a0 || awvalid !== 1'b0) begin
      n_fail++; $display("FAIL stall_pulse_ignored: aw_hs=%0d awvalid=%b want %0d 0",
                         aw_hs_cnt, awvalid, a0);
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_back_idle: got %b want 1", cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    int cnt, lat, acc;
    b_hold = 1;
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_addr = 4'hC; cmd_wdata = 32'h55AA_55AA; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0;
    cnt = 0;
    while (!bready && cnt < 20) begin @(negedge clk); cnt++; end
    n_cmp++;
    if (bready !== 1'b1) begin n_fail++; $display("FAIL reach_wr_resp: got %b want 1", bready); end
    #1 aresetn = 0;
    #1;
    n_cmp++;
    if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin
      n_fail++; $display("FAIL async_reset: got %b want 000000",
                         {awvalid, wvalid, arvalid, bready, rready, rsp_valid});
    end
    repeat (2) @(negedge clk);
    aresetn = 1;
    b_hold = 0;
    @(negedge clk);
    do_cmd(0, 4'h4, 32'h0, 4'h0, 0, lat, acc);
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL post_reset_latency: got %0d want 3", lat); end
  endtask

  task automatic test_partial_strobe();
    int lat, acc;
    fork
      do_cmd(1, 4'h8, 32'h1234_5678, 4'b0011, 0, lat, acc);
      begin
        int c;
        c = 0;
        @(negedge clk);
        while (!wvalid && c < 20) begin @(negedge clk); c++; end
        n_cmp++;
        if ({wvalid, wstrb, wdata, awaddr} !== {1'b1, 4'b0011, 32'h1234_5678, 4'h8}) begin
          n_fail++; $display("FAIL partial_bus: got v=%b strb=%b data=%h addr=%h",
                             wvalid, wstrb, wdata, awaddr);
        end
      end
    join
    do_cmd(0, 4'h8, 32'h0, 4'h0, 0, lat, acc);
  endtask

  task automatic test_back_to_back();
    int lat, acc;
    do_cmd(1, 4'h0, 32'h0BAD_F00D, 4'hF, 0, lat, acc);
    do_cmd(0, 4'h0, 32'h0, 4'h0, 0, lat, acc);
    n_cmp++;
    if (acc !== 0) begin n_fail++; $display("FAIL b2b_accept_rd: waited %0d want 0", acc); end
    n_cmp++;
    if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d want 3", lat); end
    do_cmd(1, 4'h4, 32'h7777_8888, 4'b1100, 0, lat, acc);
    n_cmp++;
    if (acc !== 0) begin n_fail++; $display("FAIL b2b_accept_wr: waited %0d want 0", acc); end
    do_cmd(0, 4'h4, 32'h0, 4'h0, 0, lat, acc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4; i++) begin
      mem[i]     = 32'hA5A5_0000 | 32'(i);
      ref_mem[i] = 32'hA5A5_0000 | 32'(i);
    end
    aresetn = 0;
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    repeat (3) @(negedge clk);
    test_reset();
    test_basic();
    test_wr_order(3, 0);
    test_wr_order(0, 3);
    test_error_resp();
    test_rsp_stall();
    test_reset_mid();
    test_partial_strobe();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_4lite_master.md
# axi_4lite_master

AXI4-Lite initiator for the register-slave subsystem: accepts single-beat read/write commands on a simple valid/ready command port and drives the AXI4-Lite AW, W, B, AR and R channels of one slave. It returns read data and response codes on a valid/ready response port. It replaces bench-style procedural mastering so firmware-side logic or a bus bridge can access slave registers in RTL. It handles one outstanding transaction at a time.

## Interface
Parameters:
- AXI_Dwidth, 32, data width in bits; must be a multiple of 8.
- AXI_Addrwidth, 4, byte address width.

Ports:
- AXI_aclk  in  1  single clock; all logic on the rising edge.
- AXI_aresetn  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command (high only in IDLE).
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  AXI_Addrwidth  target byte address.
- cmd_wdata  in  AXI_Dwidth  write data (ignored for reads).
- cmd_wstrb  in  AXI_Dwidth/8  byte strobes (ignored for reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  AXI_Dwidth  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- AXI_awaddr  out  AXI_Addrwidth; AXI_awvalid  out  1; AXI_awready  in  1.
- AXI_wdata  out  AXI_Dwidth; AXI_wstrb  out  AXI_Dwidth/8; AXI_wvalid  out  1; AXI_wready  in  1.
- AXI_bresp  in  2; AXI_bvalid  in  1; AXI_bready  out  1.
- AXI_areadaddr  out  AXI_Addrwidth; AXI_arprotect  out  3, constant 3'b000; AXI_arvalid  out  1; AXI_arready  in  1.
- AXI_rdata  in  AXI_Dwidth; AXI_rresp  in  2; AXI_rvalid  in  1; AXI_rready  out  1.

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: cmd_ready = 1. On cmd_valid:
  - Latch the address, data and strobes into registers.
  - For a write, go to WR_REQ.
  - For a read, go to RD_REQ.
- WR_REQ:
  - AXI_awvalid and AXI_wvalid are both asserted on entry.
  - Each channel has a done flag. The flag sets on its own valid&ready handshake, and that channel's valid then drops the next cycle.
  - AW and W may complete in either order or in the same cycle.
  - When both flags are set (including a cycle where the last handshake occurs), go to WR_RESP.
- WR_RESP: AXI_bready = 1. On AXI_bvalid:
  - Capture AXI_bresp.
  - Set rsp_write = 1 and rsp_rdata = 0.
  - Go to RSP.
- RD_REQ: AXI_arvalid = 1. On AXI_arready, go to RD_RESP.
- RD_RESP: AXI_rready = 1. On AXI_rvalid:
  - Capture AXI_rdata and AXI_rresp.
  - Set rsp_write = 0.
  - Go to RSP.
- RSP: rsp_valid = 1; hold all rsp_* outputs stable until rsp_ready, then go to IDLE.
- AXI rules:
  - Once asserted, a valid is never dropped before its handshake.
  - Address, data and strobe outputs are stable while their valid is high.
  - No valid depends combinationally on any ready.
- Response codes pass through unmodified. SLVERR and DECERR are reported in rsp_resp and are not retried.
- Addresses are not checked or aligned.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE; all done flags clear.
  - AXI_awvalid, AXI_wvalid, AXI_arvalid, AXI_bready, AXI_rready, rsp_valid and rsp_write go to 0.
  - AXI_awaddr, AXI_areadaddr, AXI_wdata, AXI_wstrb, rsp_rdata and rsp_resp go to 0.
  - cmd_ready goes to 1 once the block is out of reset.
- Reset mid-transaction abandons the transaction with no response. Slave resynchronisation is the system's responsibility, since both ends share AXI_aresetn.
- Minimum write latency, with the slave ready immediately:
  - Command accepted at edge 0.
  - AW/W valid during cycle 1, handshaken at edge 1.
  - bready in cycle 2; with bvalid present, handshaken at edge 2.
  - rsp_valid in cycle 3.
- Minimum read latency is the same: AR handshaken at edge 1, R at edge 2, rsp_valid in cycle 3.
- Back-to-back: the next command is accepted in the IDLE cycle after the rsp handshake. Throughput is one transaction per 4 cycles at best.
- cmd_valid outside IDLE is ignored (cmd_ready = 0).
- Slave stalls are unbounded. There is no timeout.

## Structure
- Shared package axi_4lite_pkg holds:
  - response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the master state enumeration.
  - The slave uses the same response constants.
- Single module, no sub-module.
- All outputs are registered.

## Test plan
- Write 0xDEADBEEF, strobe 4'b1111 to address 0x0, then read 0x0, against a behavioural slave -> write returns rsp_resp = 00, rsp_write = 1; read returns rsp_rdata = 0xDEADBEEF, rsp_resp = 00, rsp_valid in cycle 3 both times.
- Slave delays AXI_awready 3 cycles after AXI_wready, and a second run uses the reverse order -> each valid drops the cycle after its own handshake; exactly one B handshake follows; AW/W outputs are stable while their valid is high.
- Slave returns BRESP = 2'b10 and, in a separate read, RRESP = 2'b11 -> rsp_resp = 10 and 11 respectively; no retry occurs.
- rsp_ready held low 5 cycles -> rsp_valid and rsp_* stay stable; cmd_ready = 0 throughout; a cmd_valid pulse is ignored.
- AXI_aresetn asserted while in WR_RESP -> all valids, readys and rsp_valid go to 0 without waiting for a clock edge; after release, a read of 0x4 completes normally.
- Partial strobe 4'b0011 with data 0x12345678 to 0x8 -> AXI_wstrb = 4'b0011 on the bus; a read of 0x8 returns the slave's merged value.
